// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: jump encodings, FSM states and
// default reset/exception byte addresses.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        NOJUMP = 2'b00,
        J      = 2'b01,
        JAL    = 2'b10,
        JR     = 2'b11
    } jump_e;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and the count saturates at DEPTH; a pop on an empty stack does
// nothing. top reads as zero while the stack is empty.
module pc_ras #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 30,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     top,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
    endfunction

    assign top_idx = ptr_dec(wr_ptr_q);
    assign top     = (count_q == '0) ? '0 : mem_q[top_idx];
    assign count   = count_q;

    // Next-state for the write pointer, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && (count_q != '0)) begin
            wr_ptr_d = ptr_dec(wr_ptr_q);
            count_d  = count_q - CNT_W'(1);
        end
    end

    // Stack registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Registered program-counter sequencer: next-PC mux (exception, eret, branch,
// J/JAL, JR, sequential), stall hold, EPC and RUN/HANDLER state.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] EXC_VEC   = DEFAULT_EXC_VEC,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic [1:0]        jump,
    input  logic [25:0]       imminstr,
    input  logic [ADDR_W-1:0] aluresult,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-3:0] pc,
    output logic [ADDR_W-3:0] pcfour,
    output logic [ADDR_W-3:0] epc,
    output logic              in_exc,
    output logic [ADDR_W-3:0] ras_pred,
    output logic              ras_mispred
);

    localparam int unsigned PW = ADDR_W - 2;

    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] epc_q, epc_d;
    pc_state_e     state_q, state_d;
    jump_e         jmp;
    logic [PW-1:0] jr_target;
    logic [PW-1:0] j_target;
    logic          ras_push, ras_pop;
    logic [1:0]    unused_alu_lsbs;

    assign jmp             = jump_e'(jump);
    assign jr_target       = aluresult[ADDR_W-1:2];
    assign unused_alu_lsbs = aluresult[1:0];

    assign pc     = pc_q;
    assign pcfour = pc_q + PW'(1);
    assign epc    = epc_q;
    assign in_exc = (state_q == HANDLER);

    // Next-PC selection and RUN/HANDLER transitions; everything holds on stall.
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        state_d  = state_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        // J keeps the PC's upper word bits and replaces the low 26.
        j_target        = pc_q;
        j_target[25:0]  = imminstr;
        if (!stall) begin
            if (exc_req && (state_q == RUN)) begin
                pc_d    = EXC_VEC[ADDR_W-1:2];
                epc_d   = pc_q;
                state_d = HANDLER;
            end else if (eret && (state_q == HANDLER)) begin
                pc_d    = epc_q;
                state_d = RUN;
            end else if (branch && zero) begin
                pc_d = pcfour + {{(PW-16){imminstr[15]}}, imminstr[15:0]};
            end else if ((jmp == J) || (jmp == JAL)) begin
                pc_d     = j_target;
                ras_push = (jmp == JAL);
            end else if (jmp == JR) begin
                pc_d    = jr_target;
                ras_pop = 1'b1;
            end else begin
                pc_d = pcfour;
            end
        end
    end

    // PC, EPC and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC[ADDR_W-1:2];
            epc_q   <= '0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            state_q <= state_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [CNT_W-1:0] ras_count;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PW)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pcfour),
        .top       (ras_pred),
        .count     (ras_count)
    );

    assign ras_mispred = (jmp == JR) && (ras_count != '0) && (ras_pred != jr_target);
`else
    logic unused_ras;

    assign unused_ras  = ras_push ^ ras_pop;
    assign ras_pred    = '0;
    assign ras_mispred = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq. RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_seq;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [1:0]  jump;
    logic [25:0] imminstr;
    logic [31:0] aluresult;
    logic        exc_req;
    logic        eret;
    logic [29:0] pc;
    logic [29:0] pcfour;
    logic [29:0] epc;
    logic        in_exc;
    logic [29:0] ras_pred;
    logic        ras_mispred;

    int n_checks = 0;
    int n_errors = 0;

    pc_seq #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_3000),
        .EXC_VEC   (32'h0000_4180),
        .RAS_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .imminstr    (imminstr),
        .aluresult   (aluresult),
        .exc_req     (exc_req),
        .eret        (eret),
        .pc          (pc),
        .pcfour      (pcfour),
        .epc         (epc),
        .in_exc      (in_exc),
        .ras_pred    (ras_pred),
        .ras_mispred (ras_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
        jump = 2'b00; imminstr = '0; aluresult = '0; exc_req = 1'b0; eret = 1'b0;
        tick();
        tick();
        chk("rst_pc",      32'(pc),          32'h0C00);
        chk("rst_pcfour",  32'(pcfour),      32'h0C01);
        chk("rst_epc",     32'(epc),         32'h0);
        chk("rst_in_exc",  32'(in_exc),      32'h0);
        chk("rst_ras_pred", 32'(ras_pred),   32'h0);
        chk("rst_mispred", 32'(ras_mispred), 32'h0);
        rst_n = 1'b1;

        // free-running sequence
        chk("seq0", 32'(pc), 32'h0C00);
        tick(); chk("seq1", 32'(pc), 32'h0C01);
        tick(); chk("seq2", 32'(pc), 32'h0C02);
        tick(); tick(); tick();
        chk("seq5", 32'(pc), 32'h0C05);

        // branch taken backwards by 2 words from pcfour
        branch = 1'b1; zero = 1'b1; imminstr = 26'h000FFFE;
        tick(); chk("br_taken", 32'(pc), 32'h0C04);
        zero = 1'b0;
        tick(); chk("br_nt0", 32'(pc), 32'h0C05);
        tick(); chk("br_nt1", 32'(pc), 32'h0C06);
        branch = 1'b0;

        // stall holds a pending J
        jump = 2'b01; imminstr = 26'h0000C10; stall = 1'b1;
        tick(); chk("stall0", 32'(pc), 32'h0C06);
        tick(); chk("stall1", 32'(pc), 32'h0C06);
        stall = 1'b0;
        tick(); chk("j_target", 32'(pc), 32'h0C10);
        jump = 2'b00;

        // exception entry, ignored nested request, stalled and real eret
        exc_req = 1'b1;
        tick();
        chk("exc_pc",  32'(pc),     32'h1060);
        chk("exc_epc", 32'(epc),    32'h0C10);
        chk("exc_in",  32'(in_exc), 32'h1);
        tick();
        chk("exc2_pc",  32'(pc),     32'h1061);
        chk("exc2_epc", 32'(epc),    32'h0C10);
        chk("exc2_in",  32'(in_exc), 32'h1);
        exc_req = 1'b0;
        eret = 1'b1; stall = 1'b1;
        tick();
        chk("eret_stall_pc", 32'(pc),     32'h1061);
        chk("eret_stall_in", 32'(in_exc), 32'h1);
        stall = 1'b0;
        tick();
        chk("eret_pc", 32'(pc),     32'h0C10);
        chk("eret_in", 32'(in_exc), 32'h0);
        tick();
        chk("eret_noop_pc", 32'(pc),     32'h0C11);
        chk("eret_noop_in", 32'(in_exc), 32'h0);
        eret = 1'b0;

        // JR ignores aluresult[1:0]
        jump = 2'b11; aluresult = 32'h0000_3003;
        chk("jr_mispred_empty", 32'(ras_mispred), 32'h0);
        tick(); chk("jr_pc", 32'(pc), 32'h0C00);

        // sequential wrap from all-ones
        aluresult = 32'hFFFF_FFFC;
        tick();
        chk("jr_max_pc",  32'(pc),     32'h3FFF_FFFF);
        chk("pcfour_wrap", 32'(pcfour), 32'h0);
        jump = 2'b00;
        tick(); chk("wrap_pc", 32'(pc), 32'h0);

        // async reset in the handler
        tick();
        exc_req = 1'b1;
        tick();
        chk("pre_rst_epc", 32'(epc),    32'h1);
        chk("pre_rst_in",  32'(in_exc), 32'h1);
        exc_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc",  32'(pc),     32'h0C00);
        chk("arst_in",  32'(in_exc), 32'h0);
        chk("arst_epc", 32'(epc),    32'h0);
        tick();
        rst_n = 1'b1;

`ifdef PC_RAS_EN
        begin
            logic [31:0] exp_top [4];
            exp_top[0] = 32'h0D31; exp_top[1] = 32'h0D21;
            exp_top[2] = 32'h0D11; exp_top[3] = 32'h0D01;

            // five JALs from 0xC00; the fifth overwrites the oldest entry
            jump = 2'b10;
            for (int i = 0; i < 5; i++) begin
                imminstr = 26'(32'h0D00 + 32'(i) * 32'h10);
                tick();
            end
            chk("jal_pc", 32'(pc), 32'h0D40);
            chk("jal_top", 32'(ras_pred), 32'h0D31);

            jump = 2'b11;
            for (int i = 0; i < 4; i++) begin
                aluresult = exp_top[i] << 2;
                chk("jr_pred", 32'(ras_pred), exp_top[i]);
                chk("jr_mispred", 32'(ras_mispred), 32'h0);
                tick();
                chk("jr_pop_pc", 32'(pc), exp_top[i]);
            end
            aluresult = 32'h0000_3000;
            chk("jr_empty_mispred", 32'(ras_mispred), 32'h0);
            tick();
            chk("jr_empty_pc", 32'(pc), 32'h0C00);

            // JAL from 0xC20, then a mismatching JR
            jump = 2'b01; imminstr = 26'h0000C20;
            tick();
            jump = 2'b10; imminstr = 26'h0000C40;
            tick();
            chk("jal2_pc", 32'(pc), 32'h0C40);
            jump = 2'b11; aluresult = 32'h0000_3000;
            chk("mis_pred", 32'(ras_pred),    32'h0C21);
            chk("mis_flag", 32'(ras_mispred), 32'h1);
            tick();
            chk("mis_pc", 32'(pc), 32'h0C00);
            jump = 2'b00;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
